rr_arbiter: RTL and testbench

Round-robin arbiter that shares a single memory/bus port among 2**N requesters (instruction fetch, data access, debug, DMA). It chooses a winner with a rotating-priority scan over the request vector and holds the grant until the shared resource signals transaction completion. It then passes ownership to the next requester in rotation without an idle cycle. It sits between the requester-side interfaces and the shared port mux, and its `grant_id` drives the mux select directly.

---
 rtl/rr_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin owner selection for one shared memory/bus port among 2**N requesters.
// Latency: grant registered one edge after req (from IDLE) or after done (handover, zero bubble).
// Backpressure: the owner keeps the grant until done; req changes while BUSY are ignored.
// Ports: clk, rstn (async active-low), req[2**N], done -> grant[2**N] (one-hot),
//        grant_id[N] (binary mux select), grant_valid (any grant held).
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [(1<<N)-1:0] req,
   input  logic              done,
   output logic [(1<<N)-1:0] grant,
   output logic [N-1:0]      grant_id,
   output logic              grant_valid
);

   localparam int NR = 1 << N;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  ptr;
   logic [N-1:0]  ptr_nxt;
   logic [NR-1:0] grant_nxt;
   logic [N-1:0]  id_nxt;
   logic          valid_nxt;

   logic [NR-1:0] masked;
   logic [N-1:0]  win;
   logic          any_req;

   // Lowest set index of a vector; returns 0 for an all-zero vector
   // (callers only use the result when the vector is non-zero).
   function automatic logic [N-1:0] lowest_set(input logic [NR-1:0] v);
      logic [N-1:0] r;
      r = '0;
      for (int i = NR - 1; i >= 0; i--) begin
         if (v[i]) r = N'(i);
      end
      return r;
   endfunction

   // Rotating priority: requesters at or above ptr are preferred; if none
   // of them is asking, fall back to the lowest requester overall, which
   // is the wrap-around half of the scan.
   always_comb begin
      masked = '0;
      for (int i = 0; i < NR; i++) begin
         masked[i] = req[i] & (N'(i) >= ptr);
      end
   end

   assign any_req = |req;
   assign win     = (|masked) ? lowest_set(masked) : lowest_set(req);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      id_nxt    = grant_id;
      valid_nxt = grant_valid;
      grant_nxt = grant;

      case (state)
         IDLE: begin
            // done has no meaning without an owner, so it is not looked at here
            if (any_req) begin
               state_nxt = BUSY;
               id_nxt    = win;
               valid_nxt = 1'b1;
               grant_nxt = NR'(1) << win;
               ptr_nxt   = win + N'(1);
            end
         end
         BUSY: begin
            if (done) begin
               if (any_req) begin
                  // ptr already points past the old owner, so it ranks last;
                  // it wins again only when it is the sole requester.
                  id_nxt    = win;
                  valid_nxt = 1'b1;
                  grant_nxt = NR'(1) << win;
                  ptr_nxt   = win + N'(1);
               end else begin
                  state_nxt = IDLE;
                  id_nxt    = '0;
                  valid_nxt = 1'b0;
                  grant_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         ptr         <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         grant       <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         grant_id    <= id_nxt;
         grant_valid <= valid_nxt;
         grant       <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: self-checking bench for rr_arbiter with N=2 (four requesters).
// Latency: compares registered outputs 1 time unit after each rising edge.
// Backpressure: n/a (bench drives req/done freely).
module tb_rr_arbiter;

   localparam int N  = 2;
   localparam int NR = 1 << N;

   logic          clk;
   logic          rstn;
   logic [NR-1:0] req;
   logic          done;
   logic [NR-1:0] grant;
   logic [N-1:0]  grant_id;
   logic          grant_valid;

   int tests;
   int fails;

   // reference state: who owns the port and where the scan starts next
   logic m_valid;
   int   m_id;
   int   m_ptr;

   rr_arbiter #(.N(N)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cyclic scan starting at p: first requester found walking p, p+1, ... mod NR.
   function automatic int pick(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (p + k) % NR;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   function automatic logic [NR-1:0] m_grant();
      logic [NR-1:0] g;
      g = '0;
      if (m_valid) g[m_id] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 0;
      m_ptr   = 0;
   endtask

   // One arbitration decision, using the inputs present at the clock edge.
   task automatic model_edge();
      if (!rstn) begin
         model_reset();
      end else if (!m_valid || done) begin
         if (req != '0) begin
            m_id    = pick(req, m_ptr);
            m_valid = 1'b1;
            m_ptr   = (m_id + 1) % NR;
         end else begin
            m_valid = 1'b0;
            m_id    = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req  = '0;
      done = 1'b0;
      model_reset();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req  = 4'b1111;
      done = 1'b0;
      model_reset();
      #1;
      tests++;
      if ({grant_valid, grant_id, grant} !== 7'b0) begin
         fails++;
         $display("FAIL reset_async: got v=%0b id=%0d g=%b, want all zero", grant_valid, grant_id, grant);
      end
      tick();
      tests++;
      if ({grant_valid, grant_id, grant} !== 7'b0) begin
         fails++;
         $display("FAIL reset_held: got v=%0b id=%0d g=%b, want all zero", grant_valid, grant_id, grant);
      end
      rstn = 1'b1;
      tick();
      tests++;
      if (grant !== 4'b0001 || grant_id !== 2'd0 || grant_valid !== 1'b1 || grant !== m_grant()) begin
         fails++;
         $display("FAIL reset_first_grant: got v=%0b id=%0d g=%b, want v=1 id=0 g=0001", grant_valid, grant_id, grant);
      end
      // pointer must now be 1: a done with everyone asking hands to requester 1
      done = 1'b1;
      tick();
      done = 1'b0;
      tests++;
      if (grant_id !== 2'd1 || grant !== m_grant()) begin
         fails++;
         $display("FAIL reset_ptr: got id=%0d g=%b, want id=1 g=0010", grant_id, grant);
      end
   endtask

   task automatic test_rotation();
      do_reset();
      req = 4'b1111;
      tick();
      for (int c = 0; c < 18; c++) begin
         if (c > 0) begin
            done = (c % 3 == 0);
            tick();
         end
         tests++;
         if (grant_valid !== 1'b1 || grant_id !== 2'((c / 3) % 4) || grant !== m_grant()) begin
            fails++;
            $display("FAIL rotation c=%0d: got v=%0b id=%0d g=%b, want v=1 id=%0d", c, grant_valid, grant_id, grant, (c / 3) % 4);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b0100;
      tick();
      req  = 4'b0011;
      done = 1'b1;
      tick();
      tests++;
      if (grant_id !== 2'd0 || grant !== 4'b0001 || grant !== m_grant()) begin
         fails++;
         $display("FAIL wrap_first: got id=%0d g=%b, want id=0 g=0001", grant_id, grant);
      end
      tick();
      done = 1'b0;
      tests++;
      if (grant_id !== 2'd1 || grant !== 4'b0010 || grant !== m_grant()) begin
         fails++;
         $display("FAIL wrap_second: got id=%0d g=%b, want id=1 g=0010", grant_id, grant);
      end
   endtask

   task automatic test_sole();
      do_reset();
      req = 4'b0100;
      tick();
      done = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         tests++;
         if (grant_valid !== 1'b1 || grant_id !== 2'd2 || grant !== 4'b0100) begin
            fails++;
            $display("FAIL sole c=%0d: got v=%0b id=%0d g=%b, want v=1 id=2 g=0100", c, grant_valid, grant_id, grant);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_release();
      do_reset();
      req = 4'b0010;
      tick();
      req  = 4'b0000;
      done = 1'b1;
      tick();
      tests++;
      if ({grant_valid, grant_id, grant} !== 7'b0 || m_valid !== 1'b0) begin
         fails++;
         $display("FAIL release: got v=%0b id=%0d g=%b, want all zero", grant_valid, grant_id, grant);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if ({grant_valid, grant_id, grant} !== 7'b0) begin
            fails++;
            $display("FAIL idle_done c=%0d: got v=%0b id=%0d g=%b, want all zero", c, grant_valid, grant_id, grant);
         end
      end
      done = 1'b0;
      req  = 4'b1000;
      tick();
      tests++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd3 || grant !== 4'b1000) begin
         fails++;
         $display("FAIL release_regrant: got v=%0b id=%0d g=%b, want v=1 id=3 g=1000", grant_valid, grant_id, grant);
      end
   endtask

   task automatic test_hold();
      do_reset();
      req = 4'b1000;
      tick();
      for (int c = 0; c < 5; c++) begin
         req = (c % 2 == 0) ? 4'b0110 : 4'b0000;
         tick();
         tests++;
         if (grant !== 4'b1000 || grant_id !== 2'd3 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL hold c=%0d: got v=%0b id=%0d g=%b, want v=1 id=3 g=1000", c, grant_valid, grant_id, grant);
         end
      end
      // reset pulse between edges must clear outputs without waiting for the clock
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      tests++;
      if ({grant_valid, grant_id, grant} !== 7'b0) begin
         fails++;
         $display("FAIL hold_async_reset: got v=%0b id=%0d g=%b, want all zero", grant_valid, grant_id, grant);
      end
      tick();
      rstn = 1'b1;
      req  = '0;
   endtask

   task automatic test_fairness();
      int cnt [NR];
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      do_reset();
      req = 4'b1111;
      tick();
      for (int h = 0; h < 40; h++) begin
         int idle;
         idle = $urandom_range(0, 2);
         done = 1'b0;
         for (int k = 0; k < idle; k++) tick();
         done = 1'b1;
         tick();
         done = 1'b0;
         cnt[grant_id]++;
         tests++;
         if (grant_id !== 2'(m_id) || grant !== m_grant()) begin
            fails++;
            $display("FAIL fairness_step h=%0d: got id=%0d g=%b, want id=%0d", h, grant_id, grant, m_id);
         end
      end
      for (int i = 0; i < NR; i++) begin
         tests++;
         if (cnt[i] != 10) begin
            fails++;
            $display("FAIL fairness_count id=%0d: got %0d grants, want 10", i, cnt[i]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         req  = 4'($urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         done = ($urandom_range(0, 2) == 0);
         tick();
         tests++;
         if (grant_valid !== m_valid || grant_id !== 2'(m_id) || grant !== m_grant()) begin
            fails++;
            $display("FAIL random c=%0d: got v=%0b id=%0d g=%b, want v=%0b id=%0d g=%b",
                     c, grant_valid, grant_id, grant, m_valid, m_id, m_grant());
         end
      end
      req  = '0;
      done = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rstn  = 1'b0;
      req   = '0;
      done  = 1'b0;
      model_reset();
      test_reset();
      test_rotation();
      test_wrap();
      test_sole();
      test_release();
      test_hold();
      test_fairness();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
